// File: rtl/instr_encoder.sv
// RV32I instruction encoder that turns request fields into words and writes them to imem.
// Define ENC_IMM_CHECK_EN to reject immediates that do not fit their encodable range.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_clear,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } req_t;

  state_t            state, nstate;
  req_t              req;
  logic [31:0]       enc;
  logic              ill;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              alu_ok;
  logic [ADDR_W-1:0] wr_ptr;
  logic              clr_pend;

  assign in_ready = (state == IDLE);
  assign imem_we  = (state == WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
    end else if (in_valid && in_ready) begin
      req <= '{kind: in_kind, alu: in_alu, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    end
  end

  // funct3 shared by R-type and I-type ALU ops
  always_comb begin
    f3     = 3'b000;
    alu_ok = 1'b1;
    case (req.alu)
      3'b000, 3'b001: f3 = 3'b000;
      3'b010:         f3 = 3'b111;
      3'b011:         f3 = 3'b110;
      3'b101:         f3 = 3'b010;
      default:        alu_ok = 1'b0;
    endcase
    f7 = (req.alu == 3'b001) ? 7'b0100000 : 7'b0000000;
  end

  always_comb begin
    enc = '0;
    ill = 1'b0;
    case (req.kind)
      3'd0: enc = {req.imm[11:0], req.rs1, 3'b010, req.rd, 7'b0000011};
      3'd1: enc = {req.imm[11:5], req.rs2, req.rs1, 3'b010, req.imm[4:0], 7'b0100011};
      3'd2: begin
        enc = {f7, req.rs2, req.rs1, f3, req.rd, 7'b0110011};
        ill = !alu_ok;
      end
      3'd3: enc = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, 3'b000,
                   req.imm[4:1], req.imm[11], 7'b1100011};
      3'd4: begin
        enc = {req.imm[11:0], req.rs1, f3, req.rd, 7'b0010011};
        ill = !alu_ok || (req.alu == 3'b001);
      end
      default: ill = 1'b1;
    endcase
`ifdef ENC_IMM_CHECK_EN
    // 12-bit immediates must sign-extend from bit 11; branch offsets must be even
    if ((req.kind == 3'd0 || req.kind == 3'd1 || req.kind == 3'd4) && (req.imm[12] != req.imm[11]))
      ill = 1'b1;
    if (req.kind == 3'd3 && req.imm[0])
      ill = 1'b1;
`endif
  end

`ifndef ENC_IMM_CHECK_EN
  logic unused_imm0;
  assign unused_imm0 = req.imm[0];
`endif

  always_comb begin
    nstate = state;
    err    = 1'b0;
    case (state)
      IDLE: if (in_valid) nstate = ENC;
      ENC: begin
        if (ill) begin
          err    = 1'b1;
          nstate = IDLE;
        end else begin
          nstate = WR;
        end
      end
      WR:      if (imem_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // wr_ptr is the next free address; imem_addr holds the address of the write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_wdata <= '0;
      imem_addr  <= '0;
      wr_ptr     <= '0;
      clr_pend   <= 1'b0;
      wr_count   <= '0;
    end else begin
      if (in_clear) wr_ptr <= '0;
      if (state == ENC) begin
        imem_wdata <= enc;
        if (!ill) imem_addr <= in_clear ? '0 : wr_ptr;
      end
      if (state == WR) begin
        if (imem_ready) begin
          wr_ptr   <= (in_clear || clr_pend) ? '0 : imem_addr + ADDR_W'(4);
          clr_pend <= 1'b0;
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else if (in_clear) begin
          clr_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 10, byte-address width of imem_addr.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  encoder can accept a request.
REQ-006 in_kind  in  3  instruction kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU.
REQ-007 in_alu  in  3  ALUControl code for kinds 2/4: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-009 in_imm  in  13  signed immediate, byte offset.
REQ-010 in_clear  in  1  synchronous pulse, resets the write address to 0.
REQ-011 imem_we  out  1  instruction-memory write strobe.
REQ-012 imem_ready  in  1  memory accepts the write this cycle.
REQ-013 imem_addr  out  ADDR_W  byte address of the word being written.
REQ-014 imem_wdata  out  32  encoded instruction.
REQ-015 err  out  1  one-cycle pulse for a rejected request.
REQ-016 wr_count  out  16  completed writes since reset, saturating at 0xFFFF.

Function
REQ-017 FSM states: IDLE, ENC, WR; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: handshake on in_valid&&in_ready latches all request fields and moves to ENC.
REQ-019 ENC: exactly one cycle; registers imem_wdata; legal request -> WR; illegal request -> err=1 for that cycle, return to IDLE, no write.
REQ-020 WR: imem_we=1; addr/wdata held stable until imem_ready=1; on that cycle the write completes, addr += 4, wr_count += 1, state -> IDLE.
REQ-021 Latency: request accepted at edge N -> imem_we first high in cycle N+2; one request in flight at a time.
REQ-022 lw: imm[11:0]|rs1|010|rd|0000011. sw: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
REQ-023 R-type: funct7 (0100000 for sub, else 0)|rs2|rs1|funct3|rd|0110011; funct3 add/sub 000, slt 010, or 110, and 111.
REQ-024 beq: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
REQ-025 I-type ALU: imm[11:0]|rs1|funct3|rd|0010011; same funct3 table; in_alu=sub is illegal.
REQ-026 Illegal: in_kind>4, or in_alu outside the five listed codes for kinds 2/4.
REQ-027 Address increments modulo 2^ADDR_W; the word at the top address wraps to 0.
REQ-028 in_clear: address -> 0 next edge in any state; coincident with write completion, clear wins (next address 0); a WR in progress keeps its held address.

Reset
REQ-029 rst_n low: state IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, err=0, wr_count=0, regardless of any pending write (the write is dropped).
REQ-030 First request SHALL be acceptable in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro ENC_IMM_CHECK_EN defined: lw/sw/I-type with in_imm outside [-2048,2047], or beq with in_imm[0]=1, is illegal (err, no write).
REQ-032 ENC_IMM_CHECK_EN undefined: immediates truncated to the encodable bits, beq in_imm[0] ignored, never illegal on imm.

Verification
REQ-033 After reset, lw rd=6 rs1=9 imm=-4, imem_ready=1 -> imem_wdata=0xFFC4A303 at addr 0, imem_we high at cycle N+2.
REQ-034 sw rs2=6 rs1=9 imm=8 then R or rd=4 rs1=5 rs2=6 -> 0x0064A423 at addr 0, 0x0062E233 at addr 4, wr_count=2.
REQ-035 beq rs1=4 rs2=4 imm=8 with imem_ready low 3 cycles -> imem_we, addr, wdata=0x00420463 held stable, in_ready=0, completes on cycle 4.
REQ-036 I-type with in_alu=sub, and in_kind=7 -> err one-cycle pulse each, no imem_we, address unchanged; with ENC_IMM_CHECK_EN, lw imm=2048 -> err.
REQ-037 ADDR_W=4: four writes -> addresses 0,4,8,12, fifth at 0; in_clear on the completing edge of a write -> next address 0; rst_n low during WR -> write dropped, outputs at reset values.
